// File: rtl/segment_transition_ctrl.sv
// segment_transition_ctrl
//   Owns the active segment for NUM_SEGMENTS mod/stm segments. Holds at most
//   one pending transition request (sync-index, system-time or GPIO
//   triggered), applies immediate/external requests on the next edge, and
//   counts completed loops of the active segment against its repetition
//   field. In external mode an exhausted segment advances to the next one
//   instead of raising STOP.
module segment_transition_ctrl #(
   parameter  int NUM_SEGMENTS = 2,
   parameter  int REP_W        = 16,
   parameter  int TIME_W       = 64,
   parameter  int NUM_GPIO     = 4,
   localparam int SEG_W        = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          update_i,
   input  logic [SEG_W-1:0]              req_rd_segment_i,
   input  logic [7:0]                    transition_mode_i,
   input  logic [TIME_W-1:0]             transition_value_i,
   input  logic [NUM_SEGMENTS*REP_W-1:0] rep_i,
   input  logic [TIME_W-1:0]             sys_time_i,
   input  logic                          idx_wrap_i,
   input  logic [NUM_GPIO-1:0]           gpio_in_i,
   output logic [SEG_W-1:0]              segment_o,
   output logic                          pending_o,
   output logic                          switched_o,
   output logic                          stop_o,
   output logic [REP_W-1:0]              loop_cnt_o,
   output logic                          err_o
);

   localparam int GPIO_IDX_W = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1;
   localparam logic [SEG_W:0]      NUM_SEG_L  = (SEG_W+1)'(NUM_SEGMENTS);
   localparam logic [GPIO_IDX_W:0] NUM_GPIO_L = (GPIO_IDX_W+1)'(NUM_GPIO);
   localparam logic [REP_W-1:0]    REP_INF    = '1;

   typedef enum logic [7:0] {
      MODE_SYNC_IDX  = 8'h00,
      MODE_SYS_TIME  = 8'h01,
      MODE_GPIO      = 8'h02,
      MODE_EXT       = 8'hF0,
      MODE_IMMEDIATE = 8'hFF
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   state_e              state_q,    state_d;
   logic [SEG_W-1:0]    seg_q,      seg_d;
   logic [SEG_W-1:0]    tgt_seg_q,  tgt_seg_d;
   mode_e               mode_q,     mode_d;
   logic [TIME_W-1:0]   value_q,    value_d;
   logic                ext_q,      ext_d;
   logic                stop_q,     stop_d;
   logic [REP_W-1:0]    loop_cnt_q, loop_cnt_d;
   logic                switched_q, switched_d;
   logic                err_q,      err_d;
   logic [NUM_GPIO-1:0] gpio_prev_q;

   logic                  mode_ok;
   logic                  req_ok;
   logic                  req_direct;
   logic                  trigger;
   logic                  do_switch;
   logic [SEG_W-1:0]      switch_seg;
   logic [SEG_W-1:0]      seg_plus1;
   logic [REP_W-1:0]      rep_cur;
   logic [REP_W-1:0]      loop_inc;
   logic [NUM_GPIO-1:0]   gpio_rise;
   logic [GPIO_IDX_W-1:0] req_gpio_idx;
   logic [GPIO_IDX_W-1:0] gpio_idx_q;

   // Request validation, trigger detection and repetition lookup.
   always_comb begin
      mode_ok      = 1'b0;
      req_direct   = 1'b0;
      req_gpio_idx = transition_value_i[GPIO_IDX_W-1:0];
      case (transition_mode_i)
         MODE_SYNC_IDX, MODE_SYS_TIME: mode_ok = 1'b1;
         MODE_GPIO:                    mode_ok = ({1'b0, req_gpio_idx} < NUM_GPIO_L);
         MODE_EXT, MODE_IMMEDIATE: begin
            mode_ok    = 1'b1;
            req_direct = 1'b1;
         end
         default:                      mode_ok = 1'b0;
      endcase
      req_ok = mode_ok && ({1'b0, req_rd_segment_i} < NUM_SEG_L);

      gpio_rise  = gpio_in_i & ~gpio_prev_q;
      gpio_idx_q = value_q[GPIO_IDX_W-1:0];
      case (mode_q)
         MODE_SYNC_IDX: trigger = idx_wrap_i;
         MODE_SYS_TIME: trigger = (sys_time_i >= value_q);
         MODE_GPIO:     trigger = gpio_rise[gpio_idx_q];
         default:       trigger = 1'b0;
      endcase

      rep_cur = '0;
      for (int k = 0; k < NUM_SEGMENTS; k++) begin
         if (seg_q == SEG_W'(k)) rep_cur = rep_i[k*REP_W +: REP_W];
      end
      loop_inc  = (loop_cnt_q == REP_INF) ? loop_cnt_q : loop_cnt_q + 1'b1;
      seg_plus1 = (seg_q == SEG_W'(NUM_SEGMENTS-1)) ? '0 : seg_q + 1'b1;
   end

   // Next-state: new request beats a pending trigger, which beats loop counting.
   always_comb begin
      // NOTE: every _d gets its hold value first so no path can infer a latch.
      state_d    = state_q;
      seg_d      = seg_q;
      tgt_seg_d  = tgt_seg_q;
      mode_d     = mode_q;
      value_d    = value_q;
      ext_d      = ext_q;
      stop_d     = stop_q;
      loop_cnt_d = loop_cnt_q;
      switched_d = 1'b0;
      err_d      = update_i && !req_ok;
      do_switch  = 1'b0;
      switch_seg = seg_q;

      if (update_i && req_ok) begin
         ext_d = (transition_mode_i == MODE_EXT);
         if (req_direct) begin
            do_switch  = 1'b1;
            switch_seg = req_rd_segment_i;
            state_d    = ST_IDLE;
         end else begin
            state_d   = ST_WAIT;
            tgt_seg_d = req_rd_segment_i;
            mode_d    = mode_e'(transition_mode_i);
            value_d   = transition_value_i;
         end
      end else if (state_q == ST_WAIT && trigger) begin
         do_switch  = 1'b1;
         switch_seg = tgt_seg_q;
         state_d    = ST_IDLE;
      end

      // A wrap only counts when nothing else moved the segment this cycle.
      // An external-mode auto-advance leaves any pending request armed.
      if (!do_switch && idx_wrap_i && !stop_q) begin
         if (rep_cur != REP_INF && loop_inc >= rep_cur + 1'b1) begin
            if (ext_q) begin
               do_switch  = 1'b1;
               switch_seg = seg_plus1;
            end else begin
               stop_d     = 1'b1;
               loop_cnt_d = loop_inc;
            end
         end else begin
            loop_cnt_d = loop_inc;
         end
      end

      if (do_switch) begin
         seg_d      = switch_seg;
         switched_d = 1'b1;
         loop_cnt_d = '0;
         stop_d     = 1'b0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking so every register samples the same pre-edge values.
      gpio_prev_q <= rst_i ? '0 : gpio_in_i;
      if (rst_i) begin
         state_q    <= ST_IDLE;
         seg_q      <= '0;
         tgt_seg_q  <= '0;
         mode_q     <= MODE_IMMEDIATE;
         value_q    <= '0;
         ext_q      <= 1'b0;
         stop_q     <= 1'b0;
         loop_cnt_q <= '0;
         switched_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         seg_q      <= seg_d;
         tgt_seg_q  <= tgt_seg_d;
         mode_q     <= mode_d;
         value_q    <= value_d;
         ext_q      <= ext_d;
         stop_q     <= stop_d;
         loop_cnt_q <= loop_cnt_d;
         switched_q <= switched_d;
         err_q      <= err_d;
      end
   end

   assign segment_o  = seg_q;
   assign pending_o  = (state_q == ST_WAIT);
   assign switched_o = switched_q;
   assign stop_o     = stop_q;
   assign loop_cnt_o = loop_cnt_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_segment_transition_ctrl.sv
// Directed bench for segment_transition_ctrl: a 2-segment instance for most
// scenarios and a 3-segment instance for external-mode advance and
// out-of-range segment rejection.
module tb_segment_transition_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        update = 1'b0;
   logic        update3 = 1'b0;
   logic        req_seg = 1'b0;
   logic [1:0]  req_seg3 = 2'd0;
   logic [7:0]  mode = 8'h00;
   logic [63:0] value = 64'd0;
   logic [31:0] rep = {16'hFFFF, 16'hFFFF};
   logic [47:0] rep3 = '0;
   logic [63:0] sys_time = 64'd0;
   logic        wrap = 1'b0;
   logic        wrap3 = 1'b0;
   logic [3:0]  gpio = 4'b0000;

   logic        seg_o, pend_o, sw_o, stop_o, err_o;
   logic [15:0] loop_o;
   logic [1:0]  seg3_o;
   logic        pend3_o, sw3_o, stop3_o, err3_o;
   logic [15:0] loop3_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   segment_transition_ctrl #(.NUM_SEGMENTS(2)) dut (
      .clk_i(clk), .rst_i(rst), .update_i(update), .req_rd_segment_i(req_seg),
      .transition_mode_i(mode), .transition_value_i(value), .rep_i(rep),
      .sys_time_i(sys_time), .idx_wrap_i(wrap), .gpio_in_i(gpio),
      .segment_o(seg_o), .pending_o(pend_o), .switched_o(sw_o),
      .stop_o(stop_o), .loop_cnt_o(loop_o), .err_o(err_o)
   );

   segment_transition_ctrl #(.NUM_SEGMENTS(3)) dut3 (
      .clk_i(clk), .rst_i(rst), .update_i(update3), .req_rd_segment_i(req_seg3),
      .transition_mode_i(mode), .transition_value_i(value), .rep_i(rep3),
      .sys_time_i(sys_time), .idx_wrap_i(wrap3), .gpio_in_i(gpio),
      .segment_o(seg3_o), .pending_o(pend3_o), .switched_o(sw3_o),
      .stop_o(stop3_o), .loop_cnt_o(loop3_o), .err_o(err3_o)
   );

   // Advance one clock and land 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle UPDATE on the 2-segment instance.
   task automatic req2(input logic s, input logic [7:0] m, input logic [63:0] v);
      req_seg = s; mode = m; value = v; update = 1'b1;
      step();
      update = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      n_cmp++; if (seg_o !== 1'b0) begin n_bad++; $display("FAIL reset_seg: got %0d want 0", seg_o); end
      n_cmp++; if (pend_o !== 1'b0) begin n_bad++; $display("FAIL reset_pending: got %0b want 0", pend_o); end
      n_cmp++; if (sw_o !== 1'b0) begin n_bad++; $display("FAIL reset_switched: got %0b want 0", sw_o); end
      n_cmp++; if (stop_o !== 1'b0) begin n_bad++; $display("FAIL reset_stop: got %0b want 0", stop_o); end
      n_cmp++; if (loop_o !== 16'd0) begin n_bad++; $display("FAIL reset_loop: got %0d want 0", loop_o); end
      n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", err_o); end
      n_cmp++; if (seg3_o !== 2'd0) begin n_bad++; $display("FAIL reset_seg3: got %0d want 0", seg3_o); end
   endtask

   task automatic test_immediate();
      req2(1'b1, 8'hFF, 64'd0);
      n_cmp++; if (seg_o !== 1'b1) begin n_bad++; $display("FAIL imm_seg: got %0d want 1", seg_o); end
      n_cmp++; if (sw_o !== 1'b1) begin n_bad++; $display("FAIL imm_switched: got %0b want 1", sw_o); end
      n_cmp++; if (pend_o !== 1'b0) begin n_bad++; $display("FAIL imm_pending: got %0b want 0", pend_o); end
      step();
      n_cmp++; if (sw_o !== 1'b0) begin n_bad++; $display("FAIL imm_switched_drop: got %0b want 0", sw_o); end
   endtask

   task automatic test_sync_idx();
      // Wrap coincident with UPDATE must not fire the new request; it is a plain counted wrap.
      wrap = 1'b1;
      req2(1'b0, 8'h00, 64'd0);
      wrap = 1'b0;
      n_cmp++; if (pend_o !== 1'b1) begin n_bad++; $display("FAIL sync_pending0: got %0b want 1", pend_o); end
      n_cmp++; if (seg_o !== 1'b1) begin n_bad++; $display("FAIL sync_seg_hold: got %0d want 1", seg_o); end
      n_cmp++; if (loop_o !== 16'd1) begin n_bad++; $display("FAIL sync_loop_same_cycle: got %0d want 1", loop_o); end
      for (int i = 1; i < 3; i++) begin
         step();
         n_cmp++; if (pend_o !== 1'b1) begin n_bad++; $display("FAIL sync_pending%0d: got %0b want 1", i, pend_o); end
      end
      wrap = 1'b1;
      step();
      wrap = 1'b0;
      n_cmp++; if (seg_o !== 1'b0) begin n_bad++; $display("FAIL sync_seg: got %0d want 0", seg_o); end
      n_cmp++; if (sw_o !== 1'b1) begin n_bad++; $display("FAIL sync_switched: got %0b want 1", sw_o); end
      n_cmp++; if (pend_o !== 1'b0) begin n_bad++; $display("FAIL sync_pending_clr: got %0b want 0", pend_o); end
      n_cmp++; if (loop_o !== 16'd0) begin n_bad++; $display("FAIL sync_loop: got %0d want 0", loop_o); end
   endtask

   task automatic test_sys_time();
      logic exp_seg;
      sys_time = 64'd100;
      req2(1'b1, 8'h01, 64'd105);
      n_cmp++; if (pend_o !== 1'b1) begin n_bad++; $display("FAIL time_pending: got %0b want 1", pend_o); end
      for (int t = 101; t <= 105; t++) begin
         sys_time = 64'(t);
         step();
         exp_seg = (t >= 105) ? 1'b1 : 1'b0;
         n_cmp++; if (seg_o !== exp_seg) begin n_bad++; $display("FAIL time_seg_t%0d: got %0d want %0d", t, seg_o, exp_seg); end
      end
      n_cmp++; if (sw_o !== 1'b1) begin n_bad++; $display("FAIL time_switched: got %0b want 1", sw_o); end
      n_cmp++; if (pend_o !== 1'b0) begin n_bad++; $display("FAIL time_pending_clr: got %0b want 0", pend_o); end
      // Target already in the past: one cycle in WAIT, then switch.
      sys_time = 64'd200;
      req2(1'b0, 8'h01, 64'd50);
      n_cmp++; if (pend_o !== 1'b1 || seg_o !== 1'b1) begin n_bad++; $display("FAIL past_wait: got pend=%0b seg=%0d want pend=1 seg=1", pend_o, seg_o); end
      step();
      n_cmp++; if (seg_o !== 1'b0 || sw_o !== 1'b1) begin n_bad++; $display("FAIL past_switch: got seg=%0d sw=%0b want seg=0 sw=1", seg_o, sw_o); end
   endtask

   task automatic test_loop_stop();
      rep[15:0] = 16'd1;
      wrap = 1'b1;
      step();
      n_cmp++; if (loop_o !== 16'd1 || stop_o !== 1'b0) begin n_bad++; $display("FAIL loop_w1: got loop=%0d stop=%0b want loop=1 stop=0", loop_o, stop_o); end
      step();
      n_cmp++; if (loop_o !== 16'd2 || stop_o !== 1'b1) begin n_bad++; $display("FAIL loop_w2: got loop=%0d stop=%0b want loop=2 stop=1", loop_o, stop_o); end
      step();
      wrap = 1'b0;
      n_cmp++; if (loop_o !== 16'd2 || stop_o !== 1'b1) begin n_bad++; $display("FAIL loop_w3: got loop=%0d stop=%0b want loop=2 stop=1", loop_o, stop_o); end
      // A request still switches while stopped and clears STOP/LOOP_CNT.
      req2(1'b1, 8'hFF, 64'd0);
      n_cmp++; if (seg_o !== 1'b1 || stop_o !== 1'b0 || loop_o !== 16'd0) begin n_bad++; $display("FAIL loop_restart: got seg=%0d stop=%0b loop=%0d want seg=1 stop=0 loop=0", seg_o, stop_o, loop_o); end
   endtask

   task automatic test_ext_advance();
      logic [1:0] exp_seg;
      req_seg3 = 2'd0; mode = 8'hF0; value = 64'd0; update3 = 1'b1;
      step();
      update3 = 1'b0;
      n_cmp++; if (seg3_o !== 2'd0 || sw3_o !== 1'b1) begin n_bad++; $display("FAIL ext_enter: got seg=%0d sw=%0b want seg=0 sw=1", seg3_o, sw3_o); end
      exp_seg = 2'd0;
      for (int i = 0; i < 4; i++) begin
         exp_seg = (exp_seg == 2'd2) ? 2'd0 : exp_seg + 2'd1;
         wrap3 = 1'b1;
         step();
         wrap3 = 1'b0;
         n_cmp++; if (seg3_o !== exp_seg || sw3_o !== 1'b1 || stop3_o !== 1'b0) begin n_bad++; $display("FAIL ext_adv%0d: got seg=%0d sw=%0b stop=%0b want seg=%0d sw=1 stop=0", i, seg3_o, sw3_o, stop3_o, exp_seg); end
         step();
         n_cmp++; if (sw3_o !== 1'b0) begin n_bad++; $display("FAIL ext_sw_drop%0d: got %0b want 0", i, sw3_o); end
      end
   endtask

   task automatic test_reject();
      // Park a far-future SYS_TIME request, then send a bad mode.
      req2(1'b0, 8'h01, 64'd1000);
      req2(1'b0, 8'h05, 64'd0);
      n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL rej_mode_err: got %0b want 1", err_o); end
      n_cmp++; if (pend_o !== 1'b1 || seg_o !== 1'b1) begin n_bad++; $display("FAIL rej_mode_state: got pend=%0b seg=%0d want pend=1 seg=1", pend_o, seg_o); end
      step();
      n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rej_err_drop: got %0b want 0", err_o); end
      // Segment index 3 on a 3-segment instance.
      req_seg3 = 2'd3; mode = 8'hFF; update3 = 1'b1;
      step();
      update3 = 1'b0;
      n_cmp++; if (err3_o !== 1'b1 || seg3_o !== 2'd1 || sw3_o !== 1'b0) begin n_bad++; $display("FAIL rej_seg: got err=%0b seg=%0d sw=%0b want err=1 seg=1 sw=0", err3_o, seg3_o, sw3_o); end
   endtask

   task automatic test_gpio_replace();
      wrap = 1'b1;
      step();
      wrap = 1'b0;
      n_cmp++; if (loop_o !== 16'd1) begin n_bad++; $display("FAIL gpio_pre_loop: got %0d want 1", loop_o); end
      req2(1'b0, 8'h02, 64'd1);
      req2(1'b1, 8'h02, 64'd2);
      gpio = 4'b0010;
      step();
      n_cmp++; if (seg_o !== 1'b1 || pend_o !== 1'b1 || sw_o !== 1'b0) begin n_bad++; $display("FAIL gpio_old_dropped: got seg=%0d pend=%0b sw=%0b want seg=1 pend=1 sw=0", seg_o, pend_o, sw_o); end
      gpio = 4'b0110;
      step();
      n_cmp++; if (seg_o !== 1'b1 || sw_o !== 1'b1 || pend_o !== 1'b0) begin n_bad++; $display("FAIL gpio_new_fires: got seg=%0d sw=%0b pend=%0b want seg=1 sw=1 pend=0", seg_o, sw_o, pend_o); end
      n_cmp++; if (loop_o !== 16'd0) begin n_bad++; $display("FAIL gpio_same_seg_loop: got %0d want 0", loop_o); end
   endtask

   task automatic test_back_to_back();
      req2(1'b0, 8'h00, 64'd0);
      // New IMMEDIATE request coincides with the old trigger: new wins.
      wrap = 1'b1;
      req2(1'b1, 8'hFF, 64'd0);
      wrap = 1'b0;
      n_cmp++; if (seg_o !== 1'b1 || sw_o !== 1'b1 || pend_o !== 1'b0) begin n_bad++; $display("FAIL b2b_new_wins: got seg=%0d sw=%0b pend=%0b want seg=1 sw=1 pend=0", seg_o, sw_o, pend_o); end
      // Reset mid-WAIT with a simultaneous UPDATE.
      req2(1'b1, 8'h00, 64'd0);
      rst = 1'b1;
      req2(1'b1, 8'hFF, 64'd0);
      rst = 1'b0;
      n_cmp++; if (seg_o !== 1'b0 || pend_o !== 1'b0 || sw_o !== 1'b0) begin n_bad++; $display("FAIL rst_wins: got seg=%0d pend=%0b sw=%0b want seg=0 pend=0 sw=0", seg_o, pend_o, sw_o); end
      wrap = 1'b1;
      step();
      wrap = 1'b0;
      n_cmp++; if (seg_o !== 1'b0 || sw_o !== 1'b0) begin n_bad++; $display("FAIL rst_discard: got seg=%0d sw=%0b want seg=0 sw=0", seg_o, sw_o); end
   endtask

   initial begin
      test_reset();
      test_immediate();
      test_sync_idx();
      test_sys_time();
      test_loop_stop();
      test_ext_advance();
      test_reject();
      test_gpio_replace();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
